// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared types and default widths for the cache arbiter
package cache_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} requester_t;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
endpackage

// File: rtl/arbiter_rr_pick.sv
// arbiter_rr_pick: two-way round-robin pick, favouring the cache not granted last
module arbiter_rr_pick
  import cache_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  requester_t last_grant,
  output logic       grant_valid,
  output requester_t grant
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant = (i_req && d_req) ? (last_grant == ICACHE ? DCACHE : ICACHE)
          : (i_req ? ICACHE : DCACHE);
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache and D-cache line transactions onto one memory port
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t state, state_n;
  requester_t last_grant, grant;
  logic       grant_valid, req_write, take;

  arbiter_rr_pick u_pick (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_comb begin
    take = state == IDLE && grant_valid;
    state_n = state == IDLE ? (grant_valid ? (grant == ICACHE ? SERVE_I : SERVE_D) : IDLE)
            : (pmem_resp ? IDLE : state);
  end

  // a D request with both read and write high is serviced as a write
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= DCACHE;
      req_write    <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        last_grant   <= grant;
        req_write    <= grant == DCACHE && d_write;
        pmem_address <= grant == ICACHE ? i_address : d_address;
        if (grant == DCACHE && d_write) pmem_wdata <= d_wdata;
      end
    end
  end

  assign pmem_read  = state == SERVE_I || (state == SERVE_D && !req_write);
  assign pmem_write = state == SERVE_D && req_write;
  assign i_resp     = state == SERVE_I && pmem_resp;
  assign d_resp     = state == SERVE_D && pmem_resp;
  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;

  a_no_idle_resp: assert property (@(posedge clk) disable iff (rst) !(state == IDLE && pmem_resp));
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule
